reg_encoder: RTL

REG_ENCODER -- requirements
Module: reg_encoder

---
 rtl/reg_encoder.sv | 92 +++++++++
 1 files changed

// File: rtl/reg_encoder.sv
// Register-mask encoder: turns a 32-bit pending-register mask into a stream of ascending indices.
// Optional `remain` count port is enabled by defining REMAIN_CNT_EN.
module reg_encoder (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        load_valid,
  input  logic [31:0] load_mask,
  output logic        load_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  input  logic        out_ready,
  output logic        done
`ifdef REMAIN_CNT_EN
  ,
  output logic [5:0]  remain
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic        done_q, done_d;
  logic [4:0]  low_idx;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 32'h0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // $0 is never written, so bit 0 of a loaded mask is discarded.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          pending_d = load_mask & 32'hFFFF_FFFE;
          if (pending_d != 32'h0) state_d = ST_EMIT;
          else                    done_d  = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & (pending_q - 32'd1);
          if (pending_d == 32'h0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    low_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pending_q[i]) low_idx = i[4:0];
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_EMIT);
  assign out_index  = out_valid ? low_idx : 5'd0;
  assign done       = done_q;

`ifdef REMAIN_CNT_EN
  logic [5:0] pop_cnt;

  always_comb begin
    pop_cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      pop_cnt = pop_cnt + {5'd0, pending_q[i]};
    end
  end

  assign remain = out_valid ? pop_cnt : 6'd0;
`endif

endmodule
